// File: rtl/lts_peak_gap_detector.sv
// Long-training-symbol detector: buffers post-skip samples, matched-filters them against the LTS
// and flags detection when the two window peaks are 63..65 samples apart. Option: LTS_METRIC_OUT_EN.
module lts_peak_gap_detector #(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_SKIP   = 32,
  parameter int WIN_LEN    = 64,
  parameter int DET_DELAY  = 9
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  restart,
  input  logic [31:0]           sample_in,
  input  logic                  sample_in_strobe,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]           rd_data,
  output logic                  long_preamble_detected,
  output logic [ADDR_WIDTH-1:0] start_addr,
  output logic [ADDR_WIDTH-1:0] gap,
  output logic [2:0]            state
`ifdef LTS_METRIC_OUT_EN
  ,
  output logic [31:0]           metric,
  output logic                  metric_stb
`endif
);

  localparam int AW  = ADDR_WIDTH;
  localparam int SKW = $clog2(NUM_SKIP + 1);
  localparam int WCW = $clog2(WIN_LEN + 1);

  typedef enum logic [2:0] {
    S_SKIP   = 3'd0,
    S_FIRST  = 3'd1,
    S_SECOND = 3'd2,
    S_FAIL   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic signed [15:0] coefI(input int k);
    logic signed [15:0] v;
    case (k)
      0: v = 16'sd156;   1: v = -16'sd5;    2: v = 16'sd40;    3: v = 16'sd97;
      4: v = 16'sd21;    5: v = 16'sd60;    6: v = -16'sd115;  7: v = -16'sd38;
      8: v = 16'sd98;    9: v = 16'sd53;    10: v = 16'sd1;    11: v = -16'sd137;
      12: v = 16'sd24;   13: v = 16'sd59;   14: v = -16'sd22;  15: v = 16'sd119;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic signed [15:0] coefQ(input int k);
    logic signed [15:0] v;
    case (k)
      0: v = 16'sd0;     1: v = 16'sd120;   2: v = 16'sd111;   3: v = -16'sd83;
      4: v = -16'sd28;   5: v = 16'sd88;    6: v = 16'sd55;    7: v = 16'sd106;
      8: v = 16'sd26;    9: v = -16'sd4;    10: v = 16'sd115;  11: v = 16'sd47;
      12: v = 16'sd59;   13: v = 16'sd15;   14: v = -16'sd161; 15: v = 16'sd4;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic signed [31:0] mul16(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    return 32'(a) * 32'(b);
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  state_t          r_state, w_stateNext;
  logic            w_decide;
  logic [SKW-1:0]  r_skipCnt;
  logic [WCW-1:0]  r_winCnt;
  logic [AW-1:0]   r_waddr;
  logic [31:0]     r_mem [2**AW];
  logic [31:0]     r_rdData;
  logic [31:0]     r_taps [16];
  logic            r_vld0, r_vld1, r_vld2, r_metricStb;
  logic [AW-1:0]   r_tag0, r_tag1, r_tag2, r_metricTag;
  logic [31:0]     r_sumI, r_sumQ, w_sumI, w_sumQ;
  logic [31:0]     r_absI, r_absQ, r_metric;
  logic [31:0]     w_maxAbs, w_minAbs, w_mag;
  logic [32:0]     w_magSum;
  logic [31:0]     r_max1, r_max2;
  logic [AW-1:0]   r_addr1, r_addr2, r_startAddr, w_addr2Next, w_gapNext;
  logic            r_decPulse;
  logic [DET_DELAY-1:0] r_dly;
  logic            w_accept, w_winLast;

  assign w_accept  = enable && !restart && sample_in_strobe && (r_state != S_SKIP);
  assign w_winLast = r_metricStb && (r_winCnt == WCW'(WIN_LEN - 1));

  always_ff @(posedge clock) begin
    if (w_accept) r_mem[r_waddr] <= sample_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdData <= '0;
    end else if (enable) begin
      if (restart)    r_rdData <= '0;
      else if (rd_en) r_rdData <= r_mem[rd_addr];
    end
  end

  // Matched filter: tap 0 holds the oldest sample, each product is sample times conj(coefficient).
  always_comb begin
    w_sumI = '0;
    w_sumQ = '0;
    for (int k = 0; k < 16; k++) begin
      w_sumI = w_sumI + mul16(r_taps[k][31:16], coefI(k)) + mul16(r_taps[k][15:0], coefQ(k));
      w_sumQ = w_sumQ + mul16(r_taps[k][15:0], coefI(k)) - mul16(r_taps[k][31:16], coefQ(k));
    end
  end

  always_comb begin
    w_maxAbs = (r_absI > r_absQ) ? r_absI : r_absQ;
    w_minAbs = (r_absI > r_absQ) ? r_absQ : r_absI;
    w_magSum = {1'b0, w_maxAbs} + {3'b000, w_minAbs[31:2]};
    w_mag    = w_magSum[32] ? 32'hFFFF_FFFF : w_magSum[31:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 16; k++) r_taps[k] <= '0;
      r_vld0 <= 1'b0; r_vld1 <= 1'b0; r_vld2 <= 1'b0; r_metricStb <= 1'b0;
      r_tag0 <= '0; r_tag1 <= '0; r_tag2 <= '0; r_metricTag <= '0;
      r_sumI <= '0; r_sumQ <= '0; r_absI <= '0; r_absQ <= '0; r_metric <= '0;
    end else if (enable) begin
      if (restart) begin
        for (int k = 0; k < 16; k++) r_taps[k] <= '0;
        r_vld0 <= 1'b0; r_vld1 <= 1'b0; r_vld2 <= 1'b0; r_metricStb <= 1'b0;
        r_tag0 <= '0; r_tag1 <= '0; r_tag2 <= '0; r_metricTag <= '0;
        r_sumI <= '0; r_sumQ <= '0; r_absI <= '0; r_absQ <= '0; r_metric <= '0;
      end else begin
        if (w_accept) begin
          for (int k = 0; k < 15; k++) r_taps[k] <= r_taps[k+1];
          r_taps[15] <= sample_in;
          r_tag0     <= r_waddr;
        end
        r_vld0      <= w_accept;
        r_sumI      <= w_sumI;
        r_sumQ      <= w_sumQ;
        r_vld1      <= r_vld0;
        r_tag1      <= r_tag0;
        r_absI      <= abs32(r_sumI);
        r_absQ      <= abs32(r_sumQ);
        r_vld2      <= r_vld1;
        r_tag2      <= r_tag1;
        r_metric    <= w_mag;
        r_metricStb <= r_vld2;
        r_metricTag <= r_tag2;
      end
    end
  end

  // Gap uses the second-window address as it will stand after the closing strobe.
  always_comb begin
    w_stateNext = r_state;
    w_decide    = 1'b0;
    w_addr2Next = (r_metricStb && (r_metric > r_max2)) ? r_metricTag : r_addr2;
    w_gapNext   = w_addr2Next - r_addr1;
    case (r_state)
      S_SKIP:   if (sample_in_strobe && (r_skipCnt == SKW'(NUM_SKIP - 1))) w_stateNext = S_FIRST;
      S_FIRST:  if (w_winLast) w_stateNext = S_SECOND;
      S_SECOND: begin
        if (w_winLast) begin
          if ((w_gapNext > AW'(62)) && (w_gapNext < AW'(66))) begin
            w_stateNext = S_DONE;
            w_decide    = 1'b1;
          end else begin
            w_stateNext = S_FAIL;
          end
        end
      end
      default: w_stateNext = r_state;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    r_state <= S_SKIP;
    else if (enable) r_state <= restart ? S_SKIP : w_stateNext;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_skipCnt <= '0; r_winCnt <= '0; r_waddr <= '0;
      r_max1 <= '0; r_max2 <= '0; r_addr1 <= '0; r_addr2 <= '0;
      r_startAddr <= '0; r_decPulse <= 1'b0; r_dly <= '0;
    end else if (enable) begin
      if (restart) begin
        r_skipCnt <= '0; r_winCnt <= '0; r_waddr <= '0;
        r_max1 <= '0; r_max2 <= '0; r_addr1 <= '0; r_addr2 <= '0;
        r_startAddr <= '0; r_decPulse <= 1'b0; r_dly <= '0;
      end else begin
        if ((r_state == S_SKIP) && sample_in_strobe) r_skipCnt <= r_skipCnt + 1'b1;
        if (w_accept) r_waddr <= r_waddr + 1'b1;
        if (r_metricStb && ((r_state == S_FIRST) || (r_state == S_SECOND)))
          r_winCnt <= w_winLast ? '0 : r_winCnt + 1'b1;
        if (r_metricStb && (r_state == S_FIRST) && (r_metric > r_max1)) begin
          r_max1  <= r_metric;
          r_addr1 <= r_metricTag;
        end
        if (r_metricStb && (r_state == S_SECOND) && (r_metric > r_max2)) begin
          r_max2  <= r_metric;
          r_addr2 <= r_metricTag;
        end
        if (w_decide) r_startAddr <= r_addr1 - AW'(16);
        r_decPulse <= w_decide;
        r_dly      <= {r_dly[DET_DELAY-2:0], r_decPulse};
      end
    end
  end

  assign state                  = r_state;
  assign gap                    = r_addr2 - r_addr1;
  assign start_addr             = r_startAddr;
  assign long_preamble_detected = r_dly[DET_DELAY-1];
  assign rd_data                = r_rdData;

`ifdef LTS_METRIC_OUT_EN
  assign metric     = r_metric;
  assign metric_stb = r_metricStb;
`else
  // Metric stays internal; it only feeds the peak trackers.
`endif

endmodule

// File: tb/tb_lts_peak_gap_detector.sv
// Self-checking bench for lts_peak_gap_detector: table-driven scenarios, hand-written
// reset/buffer/freeze sequences and randomized trials against a behavioural model.
module tb_lts_peak_gap_detector;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset_n, enable, restart, sample_in_strobe, rd_en;
  logic [31:0]   sample_in;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          long_preamble_detected;
  logic [AW-1:0] start_addr, gap;
  logic [2:0]    state;
`ifdef LTS_METRIC_OUT_EN
  logic [31:0]   metric;
  logic          metric_stb;
`endif

  always #5 clock = ~clock;

  lts_peak_gap_detector dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .enable                 (enable),
    .restart                (restart),
    .sample_in              (sample_in),
    .sample_in_strobe       (sample_in_strobe),
    .rd_en                  (rd_en),
    .rd_addr                (rd_addr),
    .rd_data                (rd_data),
    .long_preamble_detected (long_preamble_detected),
    .start_addr             (start_addr),
    .gap                    (gap),
    .state                  (state)
`ifdef LTS_METRIC_OUT_EN
    ,
    .metric                 (metric),
    .metric_stb             (metric_stb)
`endif
  );

  typedef struct {
    int p1;
    int p2;
    int expState;
    int expGap;
    int expStart;
    int expPulse;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulseCnt, doneCyc, pulseCyc;
  logic [2:0] prevState = '0;

  int cI[16] = '{156, -5, 40, 97, 21, 60, -115, -38, 98, 53, 1, -137, 24, 59, -22, 119};
  int cQ[16] = '{0, 120, 111, -83, -28, 88, 55, 106, 26, -4, 115, 47, 59, 15, -161, 4};

  logic [31:0] xs [128];
  int          frzLen [128];
  logic [31:0] memModel [128];

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (state == 3'd4 && prevState != 3'd4) doneCyc = cyc;
    if (long_preamble_detected) begin
      pulseCnt++;
      pulseCyc = cyc;
    end
    prevState = state;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual,
               expected, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic stb, input logic [31:0] s,
                               input logic rst);
    @(negedge clock);
    enable           = en;
    sample_in_strobe = stb;
    sample_in        = s;
    restart          = rst;
    rd_en            = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [AW-1:0] a, input logic [31:0] expv);
    @(negedge clock);
    enable = 1'b1; sample_in_strobe = 1'b0; restart = 1'b0;
    rd_en = 1'b1; rd_addr = a;
    @(negedge clock);
    rd_en = 1'b0;
    checkOutput(name, rd_data, expv);
  endtask

  function automatic logic [31:0] mkSample(input int i, input int q);
    logic [31:0] s;
    s = {i[15:0], q[15:0]};
    return s;
  endfunction

  task automatic buildScenario(input int p1, input int p2, input int amp, input bit full);
    for (int n = 0; n < 128; n++) begin
      frzLen[n] = 0;
      if (full) xs[n] = $urandom;
      else if (amp > 0)
        xs[n] = mkSample(int'($urandom_range(2 * amp)) - amp, int'($urandom_range(2 * amp)) - amp);
      else xs[n] = '0;
    end
    for (int k = 0; k < 16; k++) begin
      if (p1 >= 15) xs[p1 - 15 + k] = mkSample(cI[k], cQ[k]);
      if (p2 >= 15) xs[p2 - 15 + k] = mkSample(cI[k], cQ[k]);
    end
  endtask

  // Reference: correlate every accepted sample, take the first strict maximum per window.
  task automatic modelRun(output int a1, output int a2, output int st, output int g,
                          output int sa);
    longint mags [128];
    longint ci, cq, bi, bq, ai, aq, mx, mn, best;
    logic signed [31:0] wi, wq;
    for (int n = 0; n < 128; n++) begin
      ci = 0; cq = 0;
      for (int k = 0; k < 16; k++) begin
        if (n - 15 + k >= 0) begin
          bi = longint'($signed(xs[n - 15 + k][31:16]));
          bq = longint'($signed(xs[n - 15 + k][15:0]));
          ci += bi * cI[k] + bq * cQ[k];
          cq += bq * cI[k] - bi * cQ[k];
        end
      end
      wi = ci[31:0];
      wq = cq[31:0];
      ai = (wi < 0) ? -longint'(wi) : longint'(wi);
      aq = (wq < 0) ? -longint'(wq) : longint'(wq);
      mx = (ai > aq) ? ai : aq;
      mn = (ai > aq) ? aq : ai;
      mags[n] = mx + (mn / 4);
      if (mags[n] > 64'hFFFF_FFFF) mags[n] = 64'hFFFF_FFFF;
    end
    best = 0; a1 = 0;
    for (int n = 0; n < 64; n++) if (mags[n] > best) begin best = mags[n]; a1 = n; end
    best = 0; a2 = 0;
    for (int n = 64; n < 128; n++) if (mags[n] > best) begin best = mags[n]; a2 = n; end
    g  = (a2 - a1) & 255;
    st = (g > 62 && g < 66) ? 4 : 3;
    sa = (st == 4) ? ((a1 - 16) & 255) : 0;
  endtask

  task automatic runScenario(input string tag);
    logic [2:0]    stBefore;
    logic [AW-1:0] gBefore;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput({tag, "_restart_state"}, state, 0);
    checkOutput({tag, "_restart_start"}, start_addr, 0);
    pulseCnt = 0; doneCyc = -1; pulseCyc = -1;
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b1, $urandom, 1'b0);
    for (int n = 0; n < 128; n++) begin
      if (frzLen[n] > 0) begin
        applyStimulus(1'b0, 1'b1, $urandom, 1'b0);
        stBefore = state;
        gBefore  = gap;
        for (int f = 1; f < frzLen[n]; f++) applyStimulus(1'b0, 1'b1, $urandom, 1'b0);
        checkOutput({tag, "_freeze_state"}, state, stBefore);
        checkOutput({tag, "_freeze_gap"}, gap, gBefore);
      end
      applyStimulus(1'b1, 1'b1, xs[n], 1'b0);
      memModel[n] = xs[n];
    end
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    for (int t = 0; t < 40 && !(state == 3'd3 || state == 3'd4); t++)
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    for (int t = 0; t < 15; t++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    vec_t tbl [8];
    int   a1, a2, st, g, sa, p1, p2, ra;
    string nm;

    tbl[0] = '{25, 89, 4, 64, 9, 1};
    tbl[1] = '{25, 95, 3, 70, 0, 0};
    tbl[2] = '{-1, -1, 3, 0, 0, 0};
    tbl[3] = '{25, 88, 4, 63, 9, 1};
    tbl[4] = '{25, 90, 4, 65, 9, 1};
    tbl[5] = '{25, 87, 3, 62, 0, 0};
    tbl[6] = '{25, 91, 3, 66, 0, 0};
    tbl[7] = '{40, 104, 4, 64, 24, 1};

    reset_n = 1'b0; enable = 1'b0; restart = 1'b0; sample_in_strobe = 1'b0;
    sample_in = '0; rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_state", state, 0);
    checkOutput("reset_rd_data", rd_data, 0);
    checkOutput("reset_pulse", long_preamble_detected, 0);
    checkOutput("reset_start", start_addr, 0);
    checkOutput("reset_gap", gap, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 31; i++) applyStimulus(1'b1, 1'b1, $urandom, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("skip31_state", state, 0);
    applyStimulus(1'b1, 1'b1, $urandom, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("skip32_state", state, 1);

    for (int v = 0; v < 8; v++) begin
      nm = $sformatf("vec%0d", v);
      buildScenario(tbl[v].p1, tbl[v].p2, 0, 1'b0);
      runScenario(nm);
      checkOutput({nm, "_state"}, state, tbl[v].expState);
      checkOutput({nm, "_gap"}, gap, tbl[v].expGap);
      checkOutput({nm, "_start"}, start_addr, tbl[v].expStart);
      checkOutput({nm, "_pulses"}, pulseCnt, tbl[v].expPulse);
      if (tbl[v].expPulse != 0) checkOutput({nm, "_pulse_delay"}, pulseCyc - doneCyc, 9);
    end

    buildScenario(25, 89, 0, 1'b0);
    runScenario("ideal");
    checkOutput("ideal_state", state, 4);
    readCheck("buf_addr25", 8'd25, 32'h0077_0004);
    readCheck("buf_addr10", 8'd10, 32'h009C_0000);
    readCheck("buf_addr30", 8'd30, 32'h0000_0000);

    buildScenario(25, 89, 0, 1'b0);
    frzLen[40] = 6;
    frzLen[100] = 3;
    runScenario("freeze");
    checkOutput("freeze_final_state", state, 4);
    checkOutput("freeze_final_gap", gap, 64);
    checkOutput("freeze_final_start", start_addr, 9);
    checkOutput("freeze_final_pulses", pulseCnt, 1);

    for (int t = 0; t < 8; t++) begin
      nm = $sformatf("rnd%0d", t);
      p1 = 15 + int'($urandom_range(44));
      p2 = p1 + 60 + int'($urandom_range(8));
      if (t % 4 == 3) buildScenario(-1, -1, 0, 1'b1);
      else buildScenario(p1, p2, 16, 1'b0);
      for (int n = 0; n < 128; n++)
        if ($urandom_range(15) == 0) frzLen[n] = 2 + int'($urandom_range(2));
      modelRun(a1, a2, st, g, sa);
      runScenario(nm);
      checkOutput({nm, "_state"}, state, st);
      checkOutput({nm, "_gap"}, gap, g);
      checkOutput({nm, "_start"}, start_addr, sa);
      checkOutput({nm, "_pulses"}, pulseCnt, (st == 4) ? 1 : 0);
      ra = int'($urandom_range(127));
      readCheck({nm, "_buf"}, AW'(ra), memModel[ra]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
